// File: rtl/rand_pkg.sv
// Shared constants and the single-step PRBS helper for the 802.16 data randomizer.
// Generator polynomial is 1 + x^14 + x^15.
package rand_pkg;

  localparam int unsigned LFSR_LEN = 15;
  localparam int unsigned TAP_A    = 14;
  localparam int unsigned TAP_B    = 15;

  // Stage k lives at vect[LFSR_LEN-k]; returns {next_state, p}.
  function automatic logic [LFSR_LEN:0] prbs_step(input logic [LFSR_LEN-1:0] state);
    logic p;
    p = state[LFSR_LEN-TAP_A] ^ state[LFSR_LEN-TAP_B];
    return {p, state[LFSR_LEN-1:1], p};
  endfunction

endpackage

// File: rtl/rand_lfsr_step.sv
// Combinational W-step unrolled PRBS chain: bit j is scrambled with the state after j steps.
module rand_lfsr_step
  import rand_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic [LFSR_LEN-1:0] state,
  input  logic [W-1:0]        in_bits,
  output logic [LFSR_LEN-1:0] next_state,
  output logic [W-1:0]        out_bits
);

  logic [LFSR_LEN-1:0] s;
  logic [LFSR_LEN:0]   r;

  always_comb begin
    s        = state;
    r        = '0;
    out_bits = '0;
    for (int j = 0; j < W; j++) begin
      r           = prbs_step(s);
      out_bits[j] = in_bits[j] ^ r[0];
      s           = r[LFSR_LEN:1];
    end
    next_state = s;
  end

endmodule

// File: rtl/randomizer_parm.sv
// IEEE 802.16 OFDM data randomizer/de-randomizer, W bits per clock, 1-cycle registered latency.
// Priority: reset, then reload (drops the cycle's data), then in_valid.
module randomizer_parm
  import rand_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        in_bits,
  input  logic                in_valid,
  output logic [W-1:0]        out_bits,
  output logic                out_valid,
  input  logic [LFSR_LEN-1:0] rand_iv,
  input  logic                reload
);

  logic [LFSR_LEN-1:0] vect;
  logic [LFSR_LEN-1:0] vect_d;
  logic [LFSR_LEN-1:0] step_state;
  logic [W-1:0]        step_out;
  logic [W-1:0]        out_bits_q, out_bits_d;
  logic                out_valid_q, out_valid_d;

  rand_lfsr_step #(
    .W (W)
  ) u_step (
    .state      (vect),
    .in_bits    (in_bits),
    .next_state (step_state),
    .out_bits   (step_out)
  );

  always_comb begin
    vect_d      = vect;
    out_bits_d  = out_bits_q;
    out_valid_d = 1'b0;
    if (reload) begin
      vect_d = rand_iv;
    end else if (in_valid) begin
      vect_d      = step_state;
      out_bits_d  = step_out;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vect        <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vect        <= vect_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_bits  = out_bits_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_randomizer_parm.sv
// Self-checking bench: fixed vectors from the standard seed sequence, corner sequences,
// a W=4 round trip, and randomized traffic against a bit-history PRBS model.
module tb_randomizer_parm;

  logic        clk = 1'b0;
  logic        rstn;
  logic [0:0]  in1, out1;
  logic        val1, rl1, ov1;
  logic [14:0] iv1;
  logic [3:0]  in4, out4, out_r;
  logic        val4, rl4, ov4, ov_r;
  logic [14:0] iv4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  randomizer_parm #(.W(1)) u1 (
    .clk(clk), .reset(rstn), .in_bits(in1), .in_valid(val1),
    .out_bits(out1), .out_valid(ov1), .rand_iv(iv1), .reload(rl1)
  );

  randomizer_parm #(.W(4)) u4 (
    .clk(clk), .reset(rstn), .in_bits(in4), .in_valid(val4),
    .out_bits(out4), .out_valid(ov4), .rand_iv(iv4), .reload(rl4)
  );

  // De-randomizer fed directly by u4, sharing its seed and reload.
  randomizer_parm #(.W(4)) ur4 (
    .clk(clk), .reset(rstn), .in_bits(out4), .in_valid(ov4),
    .out_bits(out_r), .out_valid(ov_r), .rand_iv(iv4), .reload(rl4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: generator output history; p(n) = p(n-14) ^ p(n-15). Index 0 is oldest.
  bit q1[$];
  bit q4[$];

  task automatic load_q(input int sel, input logic [14:0] seed);
    if (sel == 0) q1.delete(); else q4.delete();
    for (int k = 0; k < 15; k++) begin
      if (sel == 0) q1.push_back(seed[k]); else q4.push_back(seed[k]);
    end
  endtask

  task automatic model_adv(input int sel, input int n, input logic [3:0] d,
                           output logic [3:0] r);
    bit p;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        p = q1[0] ^ q1[1];
        q1.push_back(p);
        void'(q1.pop_front());
      end else begin
        p = q4[0] ^ q4[1];
        q4.push_back(p);
        void'(q4.pop_front());
      end
      r[i] = d[i] ^ p;
    end
  endtask

  function automatic logic [14:0] model_state(input int sel);
    logic [14:0] v;
    for (int k = 0; k < 15; k++) v[k] = (sel == 0) ? q1[k] : q4[k];
    return v;
  endfunction

  typedef struct {
    logic        reload;
    logic        valid;
    logic [14:0] iv;
    logic        bit_in;
    logic        exp_bit;
    logic        exp_valid;
    logic        chk_bit;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [15:0] seq;
    logic [3:0]  w4_exp[4];
    logic [3:0]  payload[16];
    logic [14:0] held;
    logic [3:0]  r, exp_o1, exp_o4;
    int          got;

    seq = 16'hC001;
    tbl[0] = '{reload: 1'b1, valid: 1'b0, iv: 15'h0001, bit_in: 1'b0,
               exp_bit: 1'b0, exp_valid: 1'b0, chk_bit: 1'b0};
    for (int j = 0; j < 16; j++)
      tbl[j+1] = '{reload: 1'b0, valid: 1'b1, iv: 15'h0, bit_in: 1'b0,
                   exp_bit: seq[j], exp_valid: 1'b1, chk_bit: 1'b1};
    tbl[17] = '{reload: 1'b0, valid: 1'b0, iv: 15'h0, bit_in: 1'b1,
                exp_bit: 1'b1, exp_valid: 1'b0, chk_bit: 1'b1};
    w4_exp[0] = 4'b0001; w4_exp[1] = 4'b0000; w4_exp[2] = 4'b0000; w4_exp[3] = 4'b1100;

    rstn = 1'b0; in1 = '0; val1 = 0; rl1 = 0; iv1 = '0;
    in4 = '0; val4 = 0; rl4 = 0; iv4 = '0;

    // Reset state, then lock-up pass-through.
    step();
    check("reset_vect", 32'(u1.vect), 32'h0);
    check("reset_valid", 32'(ov1), 32'h0);
    check("reset_bits", 32'(out1), 32'h0);
    check("reset_valid_w4", 32'(ov4), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val1 = 1'b1;
      in1  = (i == 1) ? 1'b0 : 1'b1;
      step();
      check("lockup_valid", 32'(ov1), 32'h1);
      check("lockup_bit", 32'(out1), (i == 1) ? 32'h0 : 32'h1);
    end
    check("lockup_vect", 32'(u1.vect), 32'h0);

    // Seed 0x0001, zero data, W=1.
    for (int i = 0; i < 18; i++) begin
      rl1 = tbl[i].reload; val1 = tbl[i].valid; iv1 = tbl[i].iv; in1 = tbl[i].bit_in;
      step();
      check("tbl_valid", 32'(ov1), 32'(tbl[i].exp_valid));
      if (tbl[i].chk_bit) check("tbl_bit", 32'(out1), 32'(tbl[i].exp_bit));
    end

    // Latency and valid gap.
    rl1 = 1'b1; iv1 = 15'h1234; val1 = 1'b0;
    step();
    rl1 = 1'b0; val1 = 1'b1; in1 = 1'b0;
    check("lat_before", 32'(ov1), 32'h0);
    step();
    check("lat_after", 32'(ov1), 32'h1);
    val1 = 1'b0;
    held = u1.vect;
    step();
    check("gap_valid", 32'(ov1), 32'h0);
    check("gap_vect_held", 32'(u1.vect), 32'(held));
    val1 = 1'b1;
    step();
    check("gap_resume", 32'(ov1), 32'h1);
    val1 = 1'b0;

    // W=4 equivalence with the W=1 seed sequence.
    rl4 = 1'b1; iv4 = 15'h0001;
    step();
    rl4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      val4 = 1'b1; in4 = 4'h0;
      step();
      check("w4_valid", 32'(ov4), 32'h1);
      check("w4_word", 32'(out4), 32'(w4_exp[i]));
    end
    val4 = 1'b0;

    // Round trip through a second instance with the same seed.
    for (int i = 0; i < 16; i++) payload[i] = 4'($urandom);
    rl4 = 1'b1; iv4 = 15'h4A80;
    step();
    rl4 = 1'b0;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      val4 = (t < 16);
      in4  = (t < 16) ? payload[t] : 4'h0;
      step();
      if (ov_r && got < 16) begin
        check("roundtrip_word", 32'(out_r), 32'(payload[got]));
        got++;
      end
    end
    check("roundtrip_count", 32'(got), 32'd16);
    val4 = 1'b0;

    // Priority: reload over valid, reset over reload.
    rl1 = 1'b1; val1 = 1'b1; iv1 = 15'h2A5A; in1 = 1'b1;
    step();
    check("prio_reload_vect", 32'(u1.vect), 32'h2A5A);
    check("prio_reload_valid", 32'(ov1), 32'h0);
    rstn = 1'b0; rl1 = 1'b1; iv1 = 15'h7FFF; val1 = 1'b0;
    step();
    check("prio_reset_vect", 32'(u1.vect), 32'h0);
    rstn = 1'b1; rl1 = 1'b0;

    // Randomized traffic against the reference model.
    load_q(0, 15'h0); load_q(1, 15'h0);
    exp_o1 = '0; exp_o4 = '0;
    for (int c = 0; c < 400; c++) begin
      logic e_v1, e_v4;
      rstn = ($urandom_range(0, 39) != 0);
      rl1  = ($urandom_range(0, 9) == 0);
      rl4  = ($urandom_range(0, 9) == 0);
      val1 = ($urandom_range(0, 3) != 0);
      val4 = ($urandom_range(0, 3) != 0);
      in1  = 1'($urandom);
      in4  = 4'($urandom);
      iv1  = 15'($urandom);
      iv4  = 15'($urandom);
      e_v1 = 1'b0; e_v4 = 1'b0;
      if (!rstn) begin
        load_q(0, 15'h0); load_q(1, 15'h0);
        exp_o1 = '0; exp_o4 = '0;
      end else begin
        if (rl1) load_q(0, iv1);
        else if (val1) begin
          model_adv(0, 1, {3'b0, in1}, r);
          exp_o1 = r; e_v1 = 1'b1;
        end
        if (rl4) load_q(1, iv4);
        else if (val4) begin
          model_adv(1, 4, in4, r);
          exp_o4 = r; e_v4 = 1'b1;
        end
      end
      step();
      check("rnd_valid1", 32'(ov1), 32'(e_v1));
      check("rnd_bits1", 32'(out1), 32'(exp_o1[0]));
      check("rnd_vect1", 32'(u1.vect), 32'(model_state(0)));
      check("rnd_valid4", 32'(ov4), 32'(e_v4));
      check("rnd_bits4", 32'(out4), 32'(exp_o4));
      check("rnd_vect4", 32'(u4.vect), 32'(model_state(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/randomizer_parm.md
Name:
randomizer_parm

Overview:
- IEEE 802.16 OFDM (WiMAX) data randomizer, parameterised to process W bits per clock.
- Each input bit is XORed with the PRBS generator 1 + x^14 + x^15, held in a 15-bit LFSR.
- The LFSR is seeded per burst from a 15-bit initialisation vector; the vector is computed outside this block from BSID, UIUC and frame number.
- Sits between MAC bit source and FEC encoder in the TX chain; the same block de-randomizes in RX.

Parameters:
- W, default 1, bits processed per clock; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_bits  input  W  data bits; in_bits[0] is earliest in time, in_bits[W-1] latest.
- in_valid  input  1  in_bits valid this cycle.
- out_bits  output  W  randomized bits, same bit ordering as in_bits.
- out_valid  output  1  out_bits valid.
- rand_iv  input  15  seed loaded into LFSR when reload=1.
- reload  input  1  load rand_iv into LFSR at this clock edge.

Behaviour:
- State register vect[14:0]: vect[14] = stage 1, vect[0] = stage 15.
- One PRBS step:
  - p = vect[1] ^ vect[0] (stages 14 and 15).
  - vect_next = {p, vect[14:1]}.
  - Output bit = data bit ^ p.
- Per cycle with in_valid=1 and reload=0:
  - Apply W chained steps. Bit j (j=0..W-1) uses the state after j steps.
  - out_bits[j] = in_bits[j] ^ p_j.
  - vect <= state after W steps.
- Registered outputs: out_bits/out_valid update at the edge that samples in_valid=1.
  - Visible the following cycle: latency 1 clock.
  - out_valid <= in_valid when no reload and no reset.
- Cycle with in_valid=0: vect holds; out_valid <= 0; out_bits holds last value.
- reload=1: vect <= rand_iv; out_valid <= 0. This cycle's in_bits are dropped, even if in_valid=1 (reload has priority).
- Reset (reset=0 at edge) has priority over everything:
  - vect <= 0, out_bits <= 0, out_valid <= 0.
  - Mid-stream reset discards in-flight data.
- All-zero vect is a lock-up state: p=0 forever, so out_bits = in_bits. This is legal; no auto-seeding.
- No backpressure; the source may assert in_valid every cycle, and throughput is W bits/clock.
- vect is readable hierarchically for debug; keep the name vect.

Decomposition:
- Package rand_pkg holds:
  - localparam LFSR_LEN = 15.
  - Tap indices (14, 15).
  - Function prbs_step(state) returning {next_state, p}.
- Sub-module rand_lfsr_step: combinational, W-deep unrolled chain.
  - Inputs: state, in_bits.
  - Outputs: next state, out word.
- Top module holds registers and reload/reset priority.

Test Plan:
- Reset: hold reset=0 one edge. Then vect=0, out_valid=0, out_bits=0. Next, in_valid=1 with bits 1,0,1 gives outputs 1,0,1 (lock-up pass-through).
- Seed and zero data, W=1: reload with rand_iv=15'h0001, then 16 cycles of in_bits=0. Required out_bits sequence: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1.
- Latency: first in_valid=1 cycle after reload gives out_valid=0 at that edge and out_valid=1 one clock later. Gap in in_valid gives a one-cycle gap in out_valid, with vect held.
- Width equivalence: W=4, same seed 15'h0001, four words of zeros. Output words 4'b0001, 4'b0000, 4'b0000, 4'b1100 (bit0 first), i.e. identical to the W=1 stream.
- Round trip: randomize a 64-bit pseudorandom payload with seed 15'h4A80, then feed the result through a second instance with the same seed. The second output equals the original payload.
- Priority: reload=1 together with in_valid=1 gives vect=rand_iv and out_valid=0 next cycle. reset=0 together with reload=1 gives vect=0.
